mem_arbiter: RTL

//  Shares the memory module (MAR + RAM) between the CPU microsequencer and a DMA/loader port.

---
 rtl/mem_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA share of MAR+RAM, each grant runs ADDR -> DATA -> RESP on the shared bus
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_drive,
  output logic [ADDR_W-1:0] bus_out,
  output logic              mem_mar_write_en,
  output logic              mem_write_en,
  output logic              mem_out_en
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;
  logic owner, we, last, c, d, any, pick, wr;
  always_ff @(posedge clk_out or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      we <= 1'b0;
      last <= 1'b1;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE || state == RESP) && any) begin
        owner <= pick;
        we <= pick ? dma_we : cpu_we;
      end
      if (state == RESP) last <= owner;
      if (state == DATA && !we && !owner) cpu_rdata <= mem_rdata;
      if (state == DATA && !we && owner) dma_rdata <= mem_rdata;
    end
  always_comb begin
    c = cpu_req && !(state == RESP && !owner);
    d = dma_req && !(state == RESP && owner);
    any = c || d;
    pick = (c && d) ? !last : d;
    state_nxt = state == ADDR ? DATA : state == DATA ? RESP : any ? ADDR : IDLE;
  end
  always_comb begin
    wr = state == DATA && we;
    cpu_gnt = state != IDLE && !owner;
    dma_gnt = state != IDLE && owner;
    cpu_done = state == RESP && !owner;
    dma_done = state == RESP && owner;
    mem_mar_write_en = state == ADDR;
    mem_write_en = wr;
    mem_out_en = state == DATA && !we;
    bus_drive = state == ADDR || wr;
    bus_out = state == ADDR ? (owner ? dma_addr : cpu_addr)
            : wr ? {{(ADDR_W-DATA_W){1'b0}}, owner ? dma_wdata : cpu_wdata} : '0;
  end
endmodule
